// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain bitstream loader.
// Optional CRC phase is enabled by defining CCFF_CRC_EN.
package ccff_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CRC   = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam logic [15:0] CRC16_POLY = 16'h1021;
   localparam logic [15:0] CRC16_INIT = 16'hFFFF;

   // Integer ceiling division used to size word counts at elaboration time.
   function automatic int ceil_div(input int a, input int b);
      return (a + b - 1) / b;
   endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Valid/ready bitstream word stream feeding the loader.
// The master (bitstream source) drives data/valid; the slave (loader) drives ready.
interface ccff_bitstream_loader_if #(
   parameter int WORD_W = 8
);
   logic [WORD_W-1:0] bs_data;
   logic              bs_valid;
   logic              bs_ready;

   modport master (output bs_data, output bs_valid, input  bs_ready);
   modport slave  (input  bs_data, input  bs_valid, output bs_ready);
endinterface

// File: rtl/ccff_crc16_serial.sv
// Bit-serial CRC-16-CCITT (poly 0x1021, init 0xFFFF), MSB-first register,
// one message bit folded in per enabled clock; i_clr reloads the init value.
// Only instantiated when CCFF_CRC_EN is defined.
import ccff_pkg::*;

module ccff_crc16_serial (
   input  logic        prog_clk,
   input  logic        pReset_n,
   input  logic        i_clr,
   input  logic        i_en,
   input  logic        i_bit,
   output logic [15:0] o_crc
);
   logic [15:0] r_crc;
   logic        w_fb;

   assign w_fb  = r_crc[15] ^ i_bit;
   assign o_crc = r_crc;

   // CRC register: clear has priority over accumulate.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      if (!pReset_n)  r_crc <= CRC16_INIT;
      else if (i_clr) r_crc <= CRC16_INIT;
      else if (i_en)  r_crc <= {r_crc[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
   end
endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words onto the I/O-tile configuration chain head, LSB first,
// one bit per ccff_shift_en cycle, exactly CHAIN_LEN bits per load, then pulses done.
// Define CCFF_CRC_EN to add a trailing CRC-16 check phase driving err.
import ccff_pkg::*;

module ccff_bitstream_loader #(
   parameter  int WORD_W    = 8,
   parameter  int CHAIN_LEN = 64,
   localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
   input  logic                    prog_clk,
   input  logic                    pReset_n,
   input  logic                    start,
   ccff_bitstream_loader_if.slave  bs,
   output logic                    ccff_head,
   output logic                    ccff_shift_en,
   input  logic                    ccff_tail,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);
   localparam int NWORDS = ceil_div(CHAIN_LEN, WORD_W);
   localparam int WCNT_W = $clog2(NWORDS + 1);
   localparam int SCNT_W = $clog2(WORD_W + 1);
   localparam logic [CNT_W-1:0]  LEN_C    = CNT_W'(CHAIN_LEN);
   localparam logic [WCNT_W-1:0] NWORDS_C = WCNT_W'(NWORDS);

   state_t              r_state, w_next;
   logic [WORD_W-1:0]   r_sreg, r_hold;
   logic [SCNT_W-1:0]   r_sreg_cnt;
   logic                r_hold_full;
   logic [WCNT_W-1:0]   r_words;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_head, r_shift_en;

   logic                w_start, w_data_ready, w_crc_ready, w_crc_last, w_hs_data;
   logic                w_shift, w_bit, w_load;
   logic [WORD_W-1:0]   w_load_word;
   logic                w_unused_tail;

   // The chain tail return is not consumed by this loader.
   assign w_unused_tail = ccff_tail;

   assign w_start      = start && (r_state == IDLE);
   assign w_data_ready = (r_state == SHIFT) && !r_hold_full && (r_words < NWORDS_C);
   assign bs.bs_ready  = w_data_ready | w_crc_ready;
   assign w_hs_data    = bs.bs_valid && w_data_ready;

   assign ccff_head     = r_head;
   assign ccff_shift_en = r_shift_en;
   assign busy          = (r_state != IDLE);
   assign done          = (r_state == DONE);

   // Bit source: drain sreg first, then refill from hold, else bypass a fresh handshake.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path infers a latch.
      w_shift     = 1'b0;
      w_bit       = 1'b0;
      w_load      = 1'b0;
      w_load_word = '0;
      if (r_state == SHIFT && r_bit_cnt < LEN_C) begin
         if (r_sreg_cnt != '0) begin
            w_shift = 1'b1;
            w_bit   = r_sreg[0];
         end else if (r_hold_full) begin
            w_shift     = 1'b1;
            w_load      = 1'b1;
            w_load_word = r_hold;
            w_bit       = r_hold[0];
         end else if (w_hs_data) begin
            w_shift     = 1'b1;
            w_load      = 1'b1;
            w_load_word = bs.bs_data;
            w_bit       = bs.bs_data[0];
         end
      end
   end

   // Next-state logic for the load sequence.
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         IDLE:  if (start) w_next = SHIFT;
         SHIFT: begin
            if (r_bit_cnt == LEN_C) begin
`ifdef CCFF_CRC_EN
               w_next = CRC;
`else
               w_next = DONE;
`endif
            end
         end
         CRC:   if (w_crc_last) w_next = DONE;
         DONE:  w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) r_state <= IDLE;
      else           r_state <= w_next;
   end

   // Datapath: shift register, holding register, counters and registered chain outputs.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_sreg      <= '0;
         r_sreg_cnt  <= '0;
         r_hold      <= '0;
         r_hold_full <= 1'b0;
         r_words     <= '0;
         r_bit_cnt   <= '0;
         r_head      <= 1'b0;
         r_shift_en  <= 1'b0;
      end else if (w_start) begin
         // Leftover bits of a partial last word from the previous load are dropped here.
         r_sreg      <= '0;
         r_sreg_cnt  <= '0;
         r_hold_full <= 1'b0;
         r_words     <= '0;
         r_bit_cnt   <= '0;
         r_shift_en  <= 1'b0;
      end else begin
         r_shift_en <= w_shift;
         if (w_shift) begin
            r_head    <= w_bit;
            r_bit_cnt <= r_bit_cnt + 1'b1;
         end
         if (w_load) begin
            r_sreg     <= w_load_word >> 1;
            r_sreg_cnt <= SCNT_W'(WORD_W - 1);
         end else if (w_shift) begin
            r_sreg     <= r_sreg >> 1;
            r_sreg_cnt <= r_sreg_cnt - 1'b1;
         end
         // A handshake lands in hold unless it was bypassed straight into sreg.
         if (w_hs_data && !(w_load && !r_hold_full)) begin
            r_hold      <= bs.bs_data;
            r_hold_full <= 1'b1;
         end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
         end
         if (w_hs_data) r_words <= r_words + 1'b1;
      end
   end

`ifdef CCFF_CRC_EN
   localparam int NCRC = ceil_div(16, WORD_W);
   localparam int CW_W = $clog2(NCRC + 1);
   localparam logic [CW_W-1:0] NCRC_C = CW_W'(NCRC);

   logic [NCRC*WORD_W-1:0] r_exp_crc;
   logic [CW_W-1:0]        r_crc_words;
   logic                   r_err;
   logic [15:0]            w_crc;

   assign w_crc_ready = (r_state == CRC) && (r_crc_words < NCRC_C);
   assign w_crc_last  = (r_crc_words == NCRC_C);
   assign err         = r_err;

   ccff_crc16_serial u_crc (
      .prog_clk (prog_clk),
      .pReset_n (pReset_n),
      .i_clr    (w_start),
      .i_en     (w_shift),
      .i_bit    (w_bit),
      .o_crc    (w_crc)
   );

   // Capture the expected CRC (LSB word first) and latch the sticky mismatch flag.
   always_ff @(posedge prog_clk or negedge pReset_n) begin
      if (!pReset_n) begin
         r_exp_crc   <= '0;
         r_crc_words <= '0;
         r_err       <= 1'b0;
      end else if (w_start) begin
         r_crc_words <= '0;
         r_err       <= 1'b0;
      end else begin
         if (w_crc_ready && bs.bs_valid) begin
            r_exp_crc[int'(r_crc_words)*WORD_W +: WORD_W] <= bs.bs_data;
            r_crc_words <= r_crc_words + 1'b1;
         end
         if (r_state == CRC && w_crc_last && (w_crc != r_exp_crc[15:0])) r_err <= 1'b1;
      end
   end
`else
   assign w_crc_ready = 1'b0;
   assign w_crc_last  = 1'b1;
   assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Scoreboard bench for ccff_bitstream_loader: two instances (CHAIN_LEN 64 and 60),
// expected chain bits queued at stimulus time, monitors pop on every ccff_shift_en.
module tb_ccff_bitstream_loader;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic         start_s   [2];
   logic [W-1:0] drv_data  [2];
   logic         drv_valid [2];
   logic w_ready[2], w_head[2], w_shift[2], w_busy[2], w_done[2], w_err[2];

   ccff_bitstream_loader_if #(.WORD_W(W)) bs0 ();
   ccff_bitstream_loader_if #(.WORD_W(W)) bs1 ();
   assign bs0.bs_data  = drv_data[0];
   assign bs0.bs_valid = drv_valid[0];
   assign w_ready[0]   = bs0.bs_ready;
   assign bs1.bs_data  = drv_data[1];
   assign bs1.bs_valid = drv_valid[1];
   assign w_ready[1]   = bs1.bs_ready;

   ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(64)) u_dut64 (
      .prog_clk(clk), .pReset_n(rst_n), .start(start_s[0]), .bs(bs0),
      .ccff_head(w_head[0]), .ccff_shift_en(w_shift[0]), .ccff_tail(1'b0),
      .busy(w_busy[0]), .done(w_done[0]), .err(w_err[0]));

   ccff_bitstream_loader #(.WORD_W(W), .CHAIN_LEN(60)) u_dut60 (
      .prog_clk(clk), .pReset_n(rst_n), .start(start_s[1]), .bs(bs1),
      .ccff_head(w_head[1]), .ccff_shift_en(w_shift[1]), .ccff_tail(1'b0),
      .busy(w_busy[1]), .done(w_done[1]), .err(w_err[1]));

   int tests = 0;
   int fails = 0;
   int len_of[2] = '{64, 60};

   bit exp_q[2][$];
   bit exp_err[2];
   int bits_seen[2];
   int stall_cycles[2];
   int done_cnt[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: one per instance, sampling on the falling edge.
   for (genvar g = 0; g < 2; g++) begin : g_mon
      bit prev_shift = 1'b0;
      bit prev_done  = 1'b0;
      always @(negedge clk) begin
         if (rst_n) begin
            if (w_shift[g]) begin
               if (exp_q[g].size() == 0) begin
                  check($sformatf("bit_count_d%0d", g), bits_seen[g] + 1, len_of[g]);
               end else begin
                  bit e;
                  e = exp_q[g].pop_front();
                  check($sformatf("head_bit%0d_d%0d", bits_seen[g], g), w_head[g], e);
               end
               bits_seen[g]++;
            end else if (bits_seen[g] > 0 && w_busy[g] && !w_done[g]) begin
               stall_cycles[g]++;
            end
            if (w_done[g]) begin
               done_cnt[g]++;
               check($sformatf("done_bits_d%0d", g), bits_seen[g], len_of[g]);
               check($sformatf("done_single_d%0d", g), prev_done, 1'b0);
               check($sformatf("err_at_done_d%0d", g), w_err[g], exp_err[g]);
`ifndef CCFF_CRC_EN
               check($sformatf("done_after_last_bit_d%0d", g), prev_shift, 1'b1);
`endif
            end
            prev_shift = w_shift[g];
            prev_done  = w_done[g];
         end else begin
            prev_shift = 1'b0;
            prev_done  = 1'b0;
         end
      end
   end

   task automatic pulse_start(input int d);
      start_s[d] = 1'b1;
      @(posedge clk); #1;
      start_s[d] = 1'b0;
   endtask

   task automatic send_word(input int d, input logic [W-1:0] w, input int gap);
      int n = 0;
      repeat (gap) begin @(posedge clk); #1; end
      drv_valid[d] = 1'b1;
      drv_data[d]  = w;
      while (n < 300) begin
         @(negedge clk);
         if (w_ready[d]) break;
         n++;
      end
      if (n >= 300) check($sformatf("ready_timeout_d%0d", d), w_ready[d], 1'b1);
      @(posedge clk); #1;
      drv_valid[d] = 1'b0;
      drv_data[d]  = W'($urandom);
   endtask

   task automatic wait_done(input int d, input int base);
      int n = 0;
      while (done_cnt[d] == base && n < 1000) begin @(posedge clk); n++; end
      check($sformatf("done_seen_d%0d", d), done_cnt[d] - base, 1);
      @(negedge clk);
      check($sformatf("busy_after_done_d%0d", d), w_busy[d], 1'b0);
   endtask

   // Reference: the chain must see the first CHAIN_LEN bits of the word stream, LSB first.
   function automatic logic [15:0] crc16_ref(input bit s[$]);
      logic [15:0] c = 16'hFFFF;
      foreach (s[i]) c = (c[15] ^ s[i]) ? ((c << 1) ^ 16'h1021) : (c << 1);
      return c;
   endfunction

   task automatic run_load(input int d, input logic [W-1:0] words[8], input int gap_at,
                           input int gap_len, input bit rnd_gaps, input int mid_start,
                           input bit flip_crc);
      bit          stream[$];
      logic [15:0] crc;
      int          base;
      for (int i = 0; i < 8; i++)
         for (int b = 0; b < W; b++)
            if (stream.size() < len_of[d]) stream.push_back(words[i][b]);
      crc = crc16_ref(stream);
      if (flip_crc) crc = crc ^ (16'h1 << $urandom_range(15, 0));
      exp_err[d]      = flip_crc;
      bits_seen[d]    = 0;
      stall_cycles[d] = 0;
      foreach (stream[i]) exp_q[d].push_back(stream[i]);
      base = done_cnt[d];
      pulse_start(d);
`ifdef CCFF_CRC_EN
      check($sformatf("err_cleared_by_start_d%0d", d), w_err[d], 1'b0);
`endif
      for (int i = 0; i < 8; i++) begin
         int gap;
         gap = (i == gap_at) ? gap_len : (rnd_gaps ? int'($urandom_range(0, 3)) : 0);
         if (i == mid_start) pulse_start(d);
         send_word(d, words[i], gap);
      end
      @(negedge clk);
      check($sformatf("ready_low_after_last_word_d%0d", d), w_ready[d], 1'b0);
`ifdef CCFF_CRC_EN
      @(posedge clk); #1;
      send_word(d, crc[7:0], 0);
      send_word(d, crc[15:8], 0);
`endif
      wait_done(d, base);
      check($sformatf("total_bits_d%0d", d), bits_seen[d], len_of[d]);
      check($sformatf("queue_drained_d%0d", d), exp_q[d].size(), 0);
   endtask

   function automatic void rand_words(output logic [W-1:0] w[8]);
      for (int i = 0; i < 8; i++) w[i] = W'($urandom);
   endfunction

   initial begin
      #200000;
      $display("FAIL global_timeout at %0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      logic [W-1:0] wv[8];
      int base;
      int n;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; drv_valid[d] = 1'b0; drv_data[d] = '0;
         exp_err[d] = 1'b0; bits_seen[d] = 0; stall_cycles[d] = 0; done_cnt[d] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_ready_d%0d", d), w_ready[d], 1'b0);
         check($sformatf("rst_head_d%0d", d),  w_head[d],  1'b0);
         check($sformatf("rst_shift_d%0d", d), w_shift[d], 1'b0);
         check($sformatf("rst_busy_d%0d", d),  w_busy[d],  1'b0);
         check($sformatf("rst_done_d%0d", d),  w_done[d],  1'b0);
         check($sformatf("rst_err_d%0d", d),   w_err[d],   1'b0);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back 0xA5.. words: gap-free 64-bit stream.
      wv = '{8'hA5, 8'h3C, 8'h0F, 8'hF0, 8'h81, 8'h7E, 8'h55, 8'hAA};
      run_load(0, wv, -1, 0, 1'b0, -1, 1'b0);
      check("stall_free_back_to_back", stall_cycles[0], 0);

      // Same words with a 5-cycle and then a 20-cycle valid gap mid-stream.
      run_load(0, wv, 4, 5, 1'b0, -1, 1'b0);
      check("short_gap_stall_bounded", stall_cycles[0] <= 5, 1'b1);
      run_load(0, wv, 4, 20, 1'b0, -1, 1'b0);
      check("long_gap_stalls", stall_cycles[0] > 0, 1'b1);

      // CHAIN_LEN=60: last word 0xFF contributes only 4 bits.
      wv = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hFF};
      run_load(1, wv, -1, 0, 1'b0, -1, 1'b0);

      // Abort after 30 bits, then a fresh full load.
      rand_words(wv);
      bits_seen[0] = 0;
      for (int i = 0; i < 4; i++)
         for (int b = 0; b < W; b++) exp_q[0].push_back(wv[i][b]);
      base = done_cnt[0];
      pulse_start(0);
      for (int i = 0; i < 4; i++) send_word(0, wv[i], 0);
      n = 0;
      while (bits_seen[0] < 30 && n < 200) begin @(posedge clk); n++; end
      check("abort_reached_30_bits", bits_seen[0] >= 30, 1'b1);
      #1 rst_n = 1'b0;
      exp_q[0].delete();
      @(negedge clk);
      check("abort_busy",  w_busy[0],  1'b0);
      check("abort_shift", w_shift[0], 1'b0);
      check("abort_ready", w_ready[0], 1'b0);
      check("abort_done",  w_done[0],  1'b0);
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      check("no_done_after_abort", done_cnt[0] - base, 0);
      rand_words(wv);
      run_load(0, wv, -1, 0, 1'b1, -1, 1'b0);

      // start pulsed while busy must not disturb the stream.
      rand_words(wv);
      run_load(0, wv, -1, 0, 1'b0, 3, 1'b0);
      rand_words(wv);
      run_load(1, wv, -1, 0, 1'b0, 6, 1'b0);

      // Randomised loads with random inter-word gaps on both instances.
      for (int r = 0; r < 6; r++) begin
         rand_words(wv);
         run_load(r % 2, wv, -1, 0, 1'b1, -1, 1'b0);
      end

`ifdef CCFF_CRC_EN
      // Corrupted CRC raises err; the next start clears it and a correct CRC keeps it low.
      rand_words(wv);
      run_load(0, wv, -1, 0, 1'b0, -1, 1'b1);
      @(negedge clk);
      check("err_sticky_after_done", w_err[0], 1'b1);
      rand_words(wv);
      run_load(0, wv, -1, 0, 1'b1, -1, 1'b0);
      rand_words(wv);
      run_load(1, wv, -1, 0, 1'b0, -1, 1'b1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
